// File: rtl/multi_dma_wc_sched.sv
// Burst-granular round-robin channel scheduler for the multi-channel write DMA.
// Grant rises 1 cycle after a channel becomes eligible, is held until sch_rdy, then waits for bst_done.
module multi_dma_wc_sched #(
    parameter int CH        = 3,
    parameter int CW        = $clog2(CH),
    parameter int BL        = 4,
    parameter int FW        = 6,
    parameter int RW        = 24,
    parameter int DELAY_CNT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CH-1:0]        cfg_we,
    input  logic [31:0]          cfg_d,
    output logic [CH*RW-1:0]     cfg_rem,
    input  logic [CH*(FW+1)-1:0] dff_cnt,
    output logic                 sch_val,
    output logic [CW-1:0]        sch_ch,
    input  logic                 sch_rdy,
    input  logic                 bst_done,
    output logic [CH-1:0]        ch_done,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, REQ, BURST, GAP} state_t;

    localparam int FL    = FW + 1;
    localparam int DW    = (DELAY_CNT > 1) ? $clog2(DELAY_CNT) : 1;
    localparam int DLAST = (DELAY_CNT > 0) ? DELAY_CNT - 1 : 0;
    localparam logic [FL-1:0] BURST_WORDS = FL'(1 << BL);

    state_t        state;
    logic [RW-1:0] rem_q [CH];
    logic [CW-1:0] ptr_q;
    logic [DW-1:0] gap_q;
    logic [CH-1:0] elig;
    logic [CW-1:0] cand;
    logic [CW-1:0] win_ch;
    logic          win_vld;
    logic          dec;

    if (RW < 32) begin : g_cfg_d_pad
        logic cfg_d_unused;
        assign cfg_d_unused = ^cfg_d[31:RW];
    end

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            cfg_rem[i*RW +: RW] = rem_q[i];
            elig[i] = (rem_q[i] != '0) && (dff_cnt[i*FL +: FL] >= BURST_WORDS);
        end
    end

    // Scan from the farthest candidate down so the nearest eligible one after ptr wins.
    always_comb begin
        win_vld = 1'b0;
        win_ch  = '0;
        cand    = '0;
        for (int d = CH; d >= 1; d--) begin
            cand = CW'((int'(ptr_q) + d) % CH);
            if (elig[cand]) begin
                win_vld = 1'b1;
                win_ch  = cand;
            end
        end
    end

    assign dec = (state == BURST) && bst_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sch_val <= 1'b0;
            sch_ch  <= '0;
            busy    <= 1'b0;
            ptr_q   <= CW'(CH - 1);
            gap_q   <= '0;
            ch_done <= '0;
            for (int i = 0; i < CH; i++) rem_q[i] <= '0;
        end else begin
            ch_done <= '0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        state   <= REQ;
                        sch_val <= 1'b1;
                        sch_ch  <= win_ch;
                        busy    <= 1'b1;
                    end
                end
                REQ: begin
                    if (sch_rdy) begin
                        state   <= BURST;
                        sch_val <= 1'b0;
                    end
                end
                BURST: begin
                    if (bst_done) begin
                        ptr_q <= sch_ch;
                        if (DELAY_CNT > 0) begin
                            state <= GAP;
                            gap_q <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (gap_q == DW'(DLAST)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_q <= gap_q + DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
            // A software write to the finishing channel overrides its decrement.
            for (int i = 0; i < CH; i++) begin
                if (cfg_we[i]) begin
                    rem_q[i] <= cfg_d[RW-1:0];
                end else if (dec && (sch_ch == CW'(i)) && (rem_q[i] != '0)) begin
                    rem_q[i] <= rem_q[i] - RW'(1);
                    if (rem_q[i] == RW'(1)) ch_done[i] <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_multi_dma_wc_sched.sv
`timescale 1ns/1ps
module tb_multi_dma_wc_sched;
    localparam int CH = 3;
    localparam int CW = 2;
    localparam int BL = 4;
    localparam int FW = 6;
    localparam int RW = 24;
    localparam int FL = FW + 1;
    localparam int BW = 1 << BL;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [CH-1:0]    cfg_we;
    logic [31:0]      cfg_d;
    logic [CH*RW-1:0] cfg_rem;
    logic [FL-1:0]    dff [CH];
    logic [CH*FL-1:0] dff_cnt;
    logic             sch_val;
    logic [CW-1:0]    sch_ch;
    logic             sch_rdy;
    logic             bst_done;
    logic [CH-1:0]    ch_done;
    logic             busy;

    logic [CH-1:0]    d_we;
    logic [CH*RW-1:0] d_rem;
    logic [CH*FL-1:0] d_dff;
    logic             d_val;
    logic [CW-1:0]    d_ch;
    logic             d_rdy;
    logic             d_done;
    logic [CH-1:0]    d_chd;
    logic             d_busy;

    always_comb for (int i = 0; i < CH; i++) dff_cnt[i*FL +: FL] = dff[i];

    multi_dma_wc_sched #(.CH(CH), .CW(CW), .BL(BL), .FW(FW), .RW(RW), .DELAY_CNT(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_d(cfg_d), .cfg_rem(cfg_rem),
        .dff_cnt(dff_cnt), .sch_val(sch_val), .sch_ch(sch_ch), .sch_rdy(sch_rdy),
        .bst_done(bst_done), .ch_done(ch_done), .busy(busy));

    multi_dma_wc_sched #(.CH(CH), .CW(CW), .BL(BL), .FW(FW), .RW(RW), .DELAY_CNT(2)) u_dly (
        .clk(clk), .rst_n(rst_n), .cfg_we(d_we), .cfg_d(cfg_d), .cfg_rem(d_rem),
        .dff_cnt(d_dff), .sch_val(d_val), .sch_ch(d_ch), .sch_rdy(d_rdy),
        .bst_done(d_done), .ch_done(d_chd), .busy(d_busy));

    int tests = 0;
    int fails = 0;
    int done_cnt [CH];

    task automatic check(input string nm, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Transaction-level model: phase 0 idle, 1 granted, 2 bursting.
    int          m_ph, m_ch, m_ptr, m_pick;
    int unsigned m_rem [CH];
    bit [CH-1:0] m_done;

    function automatic int pick();
        for (int d = 1; d <= CH; d++) begin
            int i;
            i = (m_ptr + d) % CH;
            if (m_rem[i] != 0 && dff[i] >= BW) return i;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph = 0; m_ch = 0; m_ptr = CH - 1; m_done = '0;
            for (int i = 0; i < CH; i++) m_rem[i] = 0;
        end else begin
            m_pick = pick();
            m_done = '0;
            if (m_ph == 0) begin
                if (m_pick >= 0) begin m_ch = m_pick; m_ph = 1; end
            end else if (m_ph == 1) begin
                if (sch_rdy) m_ph = 2;
            end else if (bst_done) begin
                m_ptr = m_ch;
                if (!cfg_we[m_ch] && m_rem[m_ch] != 0) begin
                    if (m_rem[m_ch] == 1) m_done[m_ch] = 1'b1;
                    m_rem[m_ch] = m_rem[m_ch] - 1;
                end
                m_ph = 0;
            end
            for (int i = 0; i < CH; i++) if (cfg_we[i]) m_rem[i] = cfg_d[RW-1:0];
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("sch_val", sch_val, m_ph == 1);
            check("busy", busy, m_ph != 0);
            if (m_ph == 1) check("sch_ch", sch_ch, m_ch);
            for (int i = 0; i < CH; i++) begin
                check($sformatf("cfg_rem[%0d]", i), cfg_rem[i*RW +: RW], m_rem[i]);
                check($sformatf("ch_done[%0d]", i), ch_done[i], m_done[i]);
                done_cnt[i] += int'(ch_done[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for a grant, optionally stall sch_rdy, then finish the burst 3 cycles after acceptance.
    task automatic run_burst(input int hold, input bit flip, input logic [CH-1:0] we,
                             input int we_at, input logic [31:0] wd, output int ch);
        int n;
        n = 0;
        ch = -1;
        while (!sch_val && n < 40) begin tick(); n++; end
        check("grant_seen", sch_val, 1);
        if (!sch_val) return;
        ch = int'(sch_ch);
        for (int k = 0; k < hold; k++) begin
            if (flip) for (int i = 0; i < CH; i++) dff[i] = (k % 2 == 1) ? 7'd0 : 7'd40;
            tick();
            check("hold_val", sch_val, 1);
            check("hold_ch", sch_ch, ch);
        end
        sch_rdy = 1'b1;
        tick();
        sch_rdy = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (k == we_at) begin cfg_we = we; cfg_d = wd; end
            if (k == 3) bst_done = 1'b1;
            tick();
            cfg_we = '0;
            bst_done = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ch, n;
        int exp2 [6];
        exp2 = '{0, 1, 2, 0, 1, 2};
        for (int i = 0; i < CH; i++) begin dff[i] = '0; done_cnt[i] = 0; end
        cfg_we = '0; cfg_d = '0; sch_rdy = 1'b0; bst_done = 1'b0;
        d_we = '0; d_dff = '0; d_rdy = 1'b0; d_done = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_val", sch_val, 0);
        check("rst_busy", busy, 0);
        check("rst_rem_nz", cfg_rem != '0, 0);
        check("rst_ch_done", ch_done, 0);
        check("rst_ch", sch_ch, 0);

        // Single channel, two bursts.
        dff[0] = 7'd16; cfg_we = 3'b001; cfg_d = 2;
        tick();
        cfg_we = '0;
        check("t1_val_early", sch_val, 0);
        tick();
        check("t1_val", sch_val, 1);
        check("t1_ch", sch_ch, 0);
        run_burst(0, 0, '0, 0, 0, ch);
        n = 0;
        while (!sch_val && n < 10) begin tick(); n++; end
        check("t1_regrant_gap", n, 1);
        run_burst(0, 0, '0, 0, 0, ch);
        check("t1_ch2", ch, 0);
        repeat (3) tick();
        check("t1_rem0", cfg_rem[RW-1:0], 0);
        check("t1_done0", done_cnt[0], 1);

        // Round robin from reset.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("t2_rst_rem_nz", cfg_rem != '0, 0);
        for (int i = 0; i < CH; i++) dff[i] = 7'd32;
        cfg_we = 3'b111; cfg_d = 4;
        tick();
        cfg_we = '0;
        for (int r = 0; r < 6; r++) begin
            run_burst(0, 0, '0, 0, 0, ch);
            check($sformatf("t2_order%0d", r), ch, exp2[r]);
        end
        check("t2_rem2", cfg_rem[2*RW +: RW], 2);

        // Lone eligible channel is re-granted; level 15 is below one burst; level 100 is unsigned.
        dff[0] = 7'd15; dff[1] = 7'd32; dff[2] = 7'd0;
        run_burst(0, 0, '0, 0, 0, ch);
        check("t3_first", ch, 1);
        run_burst(0, 0, '0, 0, 0, ch);
        check("t3_regrant", ch, 1);
        repeat (10) tick();
        check("t3_no_grant_15", sch_val, 0);
        check("t3_done1", done_cnt[1], 1);
        dff[2] = 7'd100;
        run_burst(0, 0, '0, 0, 0, ch);
        check("t3_ch2_wide", ch, 2);

        // Stall in REQ while levels change.
        dff[0] = 7'd16;
        run_burst(10, 1, '0, 0, 0, ch);
        check("t4_ch", ch, 0);
        dff[0] = 7'd16; dff[1] = 7'd0; dff[2] = 7'd100;

        // Write collides with the completing decrement; then a zero write mid-burst.
        run_burst(0, 0, 3'b100, 3, 5, ch);
        check("t5_ch", ch, 2);
        tick();
        check("t5_rem2", cfg_rem[2*RW +: RW], 5);
        check("t5_done2", done_cnt[2], 0);
        run_burst(0, 0, 3'b001, 1, 0, ch);
        check("t5_zero_ch", ch, 0);
        repeat (2) tick();
        check("t5_rem0", cfg_rem[RW-1:0], 0);
        check("t5_done0", done_cnt[0], 1);

        // Post-burst gap of two cycles.
        d_dff[FL-1:0] = 7'd16; d_we = 3'b001; cfg_d = 3;
        tick();
        d_we = '0;
        n = 0;
        while (!d_val && n < 20) begin tick(); n++; end
        check("t6_grant", d_val, 1);
        check("t6_ch", d_ch, 0);
        d_rdy = 1'b1; tick(); d_rdy = 1'b0;
        tick(); tick();
        d_done = 1'b1; tick(); d_done = 1'b0;
        check("t6_gap_busy", d_busy, 1);
        n = 0;
        while (!d_val && n < 20) begin tick(); n++; end
        check("t6_done_to_val", n, 3);
        check("t6_rem", d_rem[RW-1:0], 2);
        d_rdy = 1'b1; tick(); d_rdy = 1'b0;
        check("t6_in_burst", d_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_val", d_val, 0);
        check("t6_rst_busy", d_busy, 0);
        check("t6_rst_rem_nz", d_rem != '0, 0);
        check("t6_rst_main_val", sch_val, 0);
        check("t6_rst_main_rem_nz", cfg_rem != '0, 0);
        tick();
        rst_n = 1'b1;
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
